// File: rtl/nuart_pkg.sv
// nuart shared constants: divisor widths, oversampling ratio,
// reset divisor and the minimum legal integer divisor.
package nuart_pkg;

  localparam int unsigned NUART_DIV_W        = 16;
  localparam int unsigned NUART_FRAC_W       = 4;
  localparam int unsigned NUART_OSR          = 16;
  localparam int unsigned NUART_DEFAULT_DIV  = 50;
  localparam int unsigned NUART_DEFAULT_FRAC = 0;
  localparam int unsigned NUART_MIN_DIV      = 2;

  // Integer divisors below the minimum are raised to it.
  function automatic int unsigned nuart_clamp_div(
    input int unsigned d
  );
    return (d < NUART_MIN_DIV) ? NUART_MIN_DIV : d;
  endfunction

endpackage

// File: rtl/nuart_frac_prescaler.sv
// Fractional prescaler: integer counter, fractional accumulator and
// shadow divisor with apply-at-terminal-count.
// Ports: clk_i/rst_i (async high), en_i, div_int_i, div_frac_i,
//        div_load_i in; tc_o (terminal count), div_pending_o,
//        cfg_err_o out.
module nuart_frac_prescaler
  import nuart_pkg::*;
#(
  parameter int unsigned DIV_W        = NUART_DIV_W,
  parameter int unsigned FRAC_W       = NUART_FRAC_W,
  parameter int unsigned DEFAULT_DIV  = NUART_DEFAULT_DIV,
  parameter int unsigned DEFAULT_FRAC = NUART_DEFAULT_FRAC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  output logic              tc_o,
  output logic              div_pending_o,
  output logic              cfg_err_o
);

  localparam logic [DIV_W-1:0] MIN_DIV =
    DIV_W'(NUART_MIN_DIV);
  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(nuart_clamp_div(DEFAULT_DIV));
  localparam logic [FRAC_W-1:0] RST_FRAC =
    FRAC_W'(DEFAULT_FRAC);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [DIV_W-1:0]  sh_div_q, sh_div_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;

  logic [DIV_W:0]    last_cnt;
  logic [FRAC_W:0]   acc_sum;
  logic              apply;
  logic              sh_small;

  // Period is div_q, stretched by one when the last wrap carried.
  assign last_cnt = {1'b0, div_q}
                  + {{DIV_W{1'b0}}, ext_q}
                  - (DIV_W+1)'(1);
  assign tc_o     = en_i & ({1'b0, cnt_q} == last_cnt);
  assign apply    = pend_q & (tc_o | ~en_i);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};
  assign sh_small = sh_div_q < MIN_DIV;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ext_d     = ext_q;
    div_d     = div_q;
    frac_d    = frac_q;
    sh_div_d  = sh_div_q;
    sh_frac_d = sh_frac_q;
    pend_d    = pend_q;
    err_d     = err_q;
    if (!en_i) begin
      cnt_d = '0;
      acc_d = '0;
      ext_d = 1'b0;
    end else if (tc_o) begin
      cnt_d = '0;
      acc_d = acc_sum[FRAC_W-1:0];
      ext_d = acc_sum[FRAC_W];
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    // A fresh divisor restarts the fractional phase.
    if (apply) begin
      div_d  = sh_small ? MIN_DIV : sh_div_q;
      frac_d = sh_frac_q;
      err_d  = sh_small;
      acc_d  = '0;
      ext_d  = 1'b0;
      pend_d = 1'b0;
    end
    // A load in the apply cycle keeps the new value pending.
    if (div_load_i) begin
      sh_div_d  = div_int_i;
      sh_frac_d = div_frac_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      ext_q     <= 1'b0;
      div_q     <= RST_DIV;
      frac_q    <= RST_FRAC;
      sh_div_q  <= RST_DIV;
      sh_frac_q <= RST_FRAC;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ext_q     <= ext_d;
      div_q     <= div_d;
      frac_q    <= frac_d;
      sh_div_q  <= sh_div_d;
      sh_frac_q <= sh_frac_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign div_pending_o = pend_q;
  assign cfg_err_o     = err_q;

endmodule

// File: rtl/nuart_baudgen.sv
// Baud-rate generator: oversampling tick, bit tick and mid-bit
// sample strobe from a fractional prescaler.
// Ports: clk_i/rst_i (async high), en_i, div_int_i, div_frac_i,
//        div_load_i, rx_sync_i in; div_pending_o, cfg_err_o,
//        rx_tick_o, tx_tick_o, rx_sample_o out (all registered).
module nuart_baudgen
  import nuart_pkg::*;
#(
  parameter int unsigned DIV_W        = NUART_DIV_W,
  parameter int unsigned FRAC_W       = NUART_FRAC_W,
  parameter int unsigned OSR          = NUART_OSR,
  parameter int unsigned DEFAULT_DIV  = NUART_DEFAULT_DIV,
  parameter int unsigned DEFAULT_FRAC = NUART_DEFAULT_FRAC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              rx_sync_i,
  output logic              div_pending_o,
  output logic              cfg_err_o,
  output logic              rx_tick_o,
  output logic              tx_tick_o,
  output logic              rx_sample_o
);

  localparam int unsigned OS_W = $clog2(OSR);
  localparam logic [OS_W-1:0] MID = OS_W'(OSR/2 - 1);

  logic            tc;
  logic [OS_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [OS_W-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_tick_q, rx_tick_d;
  logic            tx_tick_q, tx_tick_d;
  logic            rx_smp_q, rx_smp_d;

  nuart_frac_prescaler #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_FRAC (DEFAULT_FRAC)
  ) u_presc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .div_int_i     (div_int_i),
    .div_frac_i    (div_frac_i),
    .div_load_i    (div_load_i),
    .tc_o          (tc),
    .div_pending_o (div_pending_o),
    .cfg_err_o     (cfg_err_o)
  );

  // Ticks are decided in the TC cycle and show up one cycle later,
  // so a sync in the TC cycle lands on that tick and wins over it.
  always_comb begin
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    rx_tick_d = tc;
    tx_tick_d = tc & (tx_cnt_q == '0);
    rx_smp_d  = tc & ~rx_sync_i & (rx_cnt_q == MID);
    if (!en_i) begin
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end else begin
      if (tc) tx_cnt_d = tx_cnt_q + OS_W'(1);
      if (rx_sync_i) rx_cnt_d = '0;
      else if (tc)   rx_cnt_d = rx_cnt_q + OS_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
      rx_smp_q  <= 1'b0;
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
      rx_smp_q  <= rx_smp_d;
    end
  end

  assign rx_tick_o   = rx_tick_q;
  assign tx_tick_o   = tx_tick_q;
  assign rx_sample_o = rx_smp_q;

endmodule

// File: tb/tb_nuart_baudgen.sv
// Bench for nuart_baudgen: directed scenarios plus random traffic
// against an event-scheduled reference model.
module tb_nuart_baudgen;

  localparam int OSR = 16;
  localparam int FW  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic [3:0]  frac_in;
  logic        load;
  logic        sync;
  logic        pend_o;
  logic        err_o;
  logic        rx_tick;
  logic        tx_tick;
  logic        smp;

  nuart_baudgen dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .div_int_i     (div_in),
    .div_frac_i    (frac_in),
    .div_load_i    (load),
    .rx_sync_i     (sync),
    .div_pending_o (pend_o),
    .cfg_err_o     (err_o),
    .rx_tick_o     (rx_tick),
    .tx_tick_o     (tx_tick),
    .rx_sample_o   (smp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int t0     = 0;

  // Reference model: periods scheduled as absolute cycle spans.
  int m_div, m_frac, m_err, m_pend;
  int sh_div, sh_frac;
  int acc, carry;
  int pstart, plen;
  int txn, rxn;
  bit e_rx, e_tx, e_smp;

  int rx_q[$];
  int tx_q[$];
  int smp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d",
             tag, obs, exp, cyc_n);
    end
  endtask

  task automatic m_reset();
    m_div  = 50;
    m_frac = 0;
    m_err  = 0;
    m_pend = 0;
    sh_div = 50;
    sh_frac = 0;
    acc    = 0;
    carry  = 0;
    txn    = 0;
    rxn    = 0;
    pstart = cyc_n + 1;
    plen   = 50;
    e_rx   = 0;
    e_tx   = 0;
    e_smp  = 0;
  endtask

  task automatic m_step();
    bit tc;
    bit ap;
    tc    = en && (cyc_n == pstart + plen - 1);
    e_rx  = tc;
    e_tx  = tc && (txn % OSR == 0);
    e_smp = tc && !sync && (rxn % OSR == OSR/2 - 1);
    ap    = (m_pend != 0) && (tc || !en);
    if (tc) begin
      txn++;
      acc  += m_frac;
      carry = acc / (1 << FW);
      acc   = acc % (1 << FW);
    end
    if (!en) begin
      acc = 0; carry = 0; txn = 0; rxn = 0;
    end else if (sync) begin
      rxn = 0;
    end else if (tc) begin
      rxn++;
    end
    if (ap) begin
      m_div  = (sh_div < 2) ? 2 : sh_div;
      m_frac = sh_frac;
      m_err  = (sh_div < 2) ? 1 : 0;
      acc    = 0;
      carry  = 0;
      m_pend = 0;
    end
    if (load) begin
      sh_div  = int'(div_in);
      sh_frac = int'(frac_in);
      m_pend  = 1;
    end
    if (!en || tc) begin
      pstart = cyc_n + 1;
      plen   = m_div + carry;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset();
    else     m_step();
    cyc_n++;
    #1;
    chk("rx_tick", rx_tick, int'(e_rx));
    chk("tx_tick", tx_tick, int'(e_tx));
    chk("rx_sample", smp, int'(e_smp));
    chk("pending", pend_o, m_pend);
    chk("cfg_err", err_o, m_err);
    if (rx_tick === 1'b1) rx_q.push_back(cyc_n);
    if (tx_tick === 1'b1) tx_q.push_back(cyc_n);
    if (smp === 1'b1)     smp_q.push_back(cyc_n);
  endtask

  task automatic run_to(input int abs_c);
    while (cyc_n < abs_c) cyc();
  endtask

  initial begin
    int hit;
    rst = 1'b1; en = 1'b0; load = 1'b0; sync = 1'b0;
    div_in = '0; frac_in = '0;
    m_reset();
    repeat (3) cyc();
    chk("rst_rx_tick", rx_tick, 0);
    chk("rst_pending", pend_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    repeat (2) cyc();

    // Default divisor from enable.
    en = 1'b1;
    t0 = cyc_n;
    rx_q.delete(); tx_q.delete(); smp_q.delete();
    run_to(t0 + 1660);
    chk("def_rx0", rx_q[0] - t0, 50);
    chk("def_rx1", rx_q[1] - t0, 100);
    chk("def_rx_n", rx_q.size(), 33);
    chk("def_tx_n", tx_q.size(), 3);
    chk("def_tx0", tx_q[0] - t0, 50);
    chk("def_tx1", tx_q[1] - t0, 850);
    chk("def_tx2", tx_q[2] - t0, 1650);

    // Sync, then a sync in the TC cycle of the would-be sample tick.
    smp_q.delete(); rx_q.delete();
    sync = 1'b1; cyc(); sync = 1'b0;
    run_to(t0 + 2049);
    sync = 1'b1; cyc(); sync = 1'b0;
    run_to(t0 + 2460);
    chk("sync_smp_n", smp_q.size(), 1);
    chk("sync_smp_at", smp_q[0] - t0, 2450);
    hit = 0;
    foreach (rx_q[i]) if (rx_q[i] - t0 == 2050) hit = 1;
    chk("sync_tick_kept", hit, 1);

    // Load div=20 mid-period.
    div_in = 16'd20; frac_in = 4'd0;
    load = 1'b1; cyc(); load = 1'b0;
    chk("pend_rise", pend_o, 1);
    rx_q.delete();
    run_to(t0 + 2499);
    chk("pend_hold", pend_o, 1);
    cyc();
    chk("pend_fall", pend_o, 0);
    run_to(t0 + 2545);
    chk("ld_n", rx_q.size(), 3);
    chk("ld_rx0", rx_q[0] - t0, 2500);
    chk("ld_rx1", rx_q[1] - t0, 2520);
    chk("ld_rx2", rx_q[2] - t0, 2540);

    // Fractional divisor 10 + 8/16.
    div_in = 16'd10; frac_in = 4'd8;
    load = 1'b1; cyc(); load = 1'b0;
    rx_q.delete();
    run_to(t0 + 2760);
    chk("frac_rx0", rx_q[0] - t0, 2560);
    chk("frac_p10", rx_q[2] - rx_q[1], 10);
    chk("frac_p11", rx_q[3] - rx_q[2], 11);
    chk("frac_span16", rx_q[17] - rx_q[1], 168);

    // Clamp and recovery.
    div_in = 16'd1; frac_in = 4'd0;
    load = 1'b1; cyc(); load = 1'b0;
    run_to(t0 + 2800);
    rx_q.delete();
    run_to(t0 + 2820);
    chk("clamp_err", err_o, 1);
    chk("clamp_per", rx_q[1] - rx_q[0], 2);
    chk("clamp_n", rx_q.size(), 10);
    div_in = 16'd5;
    load = 1'b1; cyc(); load = 1'b0;
    run_to(t0 + 2860);
    rx_q.delete();
    run_to(t0 + 2900);
    chk("unclamp_err", err_o, 0);
    chk("unclamp_per", rx_q[1] - rx_q[0], 5);
    chk("unclamp_n", rx_q.size(), 8);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      load = ($urandom_range(0, 99) < 2);
      if (load) begin
        div_in  = 16'($urandom_range(0, 12));
        frac_in = 4'($urandom_range(0, 15));
      end
      sync = ($urandom_range(0, 99) < 3);
      cyc();
    end
    load = 1'b0; sync = 1'b0; en = 1'b1;
    repeat (5) cyc();

    // Reset mid-period with a load pending.
    div_in = 16'd20; frac_in = 4'd0;
    load = 1'b1; cyc(); load = 1'b0;
    chk("pre_rst_pend", pend_o, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pend", pend_o, 0);
    chk("arst_rx", rx_tick, 0);
    chk("arst_tx", tx_tick, 0);
    chk("arst_smp", smp, 0);
    chk("arst_err", err_o, 0);
    en = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    en = 1'b1;
    t0 = cyc_n;
    rx_q.delete();
    run_to(t0 + 60);
    chk("post_rst_rx0", rx_q[0] - t0, 50);
    chk("post_rst_n", rx_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
